// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache between the CPU load/store
// path and a slow backing memory. Read hits finish in the request cycle; misses and stores stall.
module dcache_direct #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int INDEX_WIDTH = 4,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic                  cpu_re,
   input  logic                  cpu_we,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic [CNT_WIDTH-1:0]  miss_count
);

   localparam int LINES     = 2 ** INDEX_WIDTH;
   localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      WRITE
   } state_e;

   state_e                  state_q, state_d;
   logic [LINES-1:0]        valid_q, valid_d;
   logic [TAG_WIDTH-1:0]    tag_q  [LINES];
   logic [TAG_WIDTH-1:0]    tag_d  [LINES];
   logic [DATA_WIDTH-1:0]   data_q [LINES];
   logic [DATA_WIDTH-1:0]   data_d [LINES];
   logic [ADDR_WIDTH-3:0]   addr_q, addr_d;      // latched word address
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [CNT_WIDTH-1:0]    miss_count_q, miss_count_d;
   logic                    done_q, done_d;

   logic [INDEX_WIDTH-1:0]  cpu_index, lat_index;
   logic [TAG_WIDTH-1:0]    cpu_tag, lat_tag;
   logic                    cpu_hit, lat_hit;
   logic                    unused_addr_bits;

   assign cpu_index = cpu_addr[INDEX_WIDTH+1:2];
   assign cpu_tag   = cpu_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
   assign lat_index = addr_q[INDEX_WIDTH-1:0];
   assign lat_tag   = addr_q[ADDR_WIDTH-3:INDEX_WIDTH];

   assign cpu_hit = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);
   assign lat_hit = valid_q[lat_index] && (tag_q[lat_index] == lat_tag);

   // Byte-offset bits are meaningless for word-only accesses.
   assign unused_addr_bits = ^cpu_addr[1:0];

   assign miss_count = miss_count_q;

   // NOTE: every variable gets a default before the case so no latch can be inferred.
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      tag_d        = tag_q;
      data_d       = data_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      miss_count_d = miss_count_q;
      done_d       = 1'b0;

      stall     = 1'b0;
      cpu_rdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;

      unique case (state_q)
         IDLE: begin
            // The cycle right after a store completes is the CPU's commit cycle, not a new store.
            if (cpu_we && !done_q) begin
               stall   = 1'b1;
               addr_d  = cpu_addr[ADDR_WIDTH-1:2];
               wdata_d = cpu_wdata;
               state_d = WRITE;
            end else if (cpu_re && !cpu_we) begin
               if (cpu_hit) begin
                  cpu_rdata = data_q[cpu_index];
               end else begin
                  stall   = 1'b1;
                  addr_d  = cpu_addr[ADDR_WIDTH-1:2];
                  state_d = FILL;
                  if (miss_count_q != '1) begin
                     miss_count_d = miss_count_q + CNT_WIDTH'(1);
                  end
               end
            end
         end

         FILL: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = {addr_q, 2'b00};
            if (mem_ack) begin
               valid_d[lat_index] = 1'b1;
               tag_d[lat_index]   = lat_tag;
               data_d[lat_index]  = mem_rdata;
               state_d            = IDLE;
            end
         end

         WRITE: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {addr_q, 2'b00};
            mem_wdata = wdata_q;
            if (mem_ack) begin
               if (lat_hit) begin
                  data_d[lat_index] = wdata_q;
               end
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         miss_count_q <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         miss_count_q <= miss_count_d;
         done_q       <= done_d;
      end
   end

   // NOTE: tag/data storage and the request latches are deliberately not reset; the valid
   // bits and the FSM state make their contents irrelevant until they are written.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_q   <= tag_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

endmodule

// File: tb/tb_dcache_direct.sv
// Self-checking bench for dcache_direct: directed vector table, reset/commit corner cases,
// and randomized traffic against a word-address-level cache model with a backing memory.
module tb_dcache_direct;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int IW    = 4;
   localparam int CW    = 16;
   localparam int LINES = 2 ** IW;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] cpu_addr;
   logic          cpu_re;
   logic          cpu_we;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          stall;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;
   logic [CW-1:0] miss_count;

   always #5 clk = ~clk;

   dcache_direct #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .INDEX_WIDTH(IW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_addr  (cpu_addr),
      .cpu_re    (cpu_re),
      .cpu_we    (cpu_we),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .miss_count(miss_count)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Backing memory plus reference cache: each line remembers the full word address it holds.
   logic [31:0] backing [logic [31:0]];
   bit          m_valid [LINES];
   logic [31:0] m_waddr [LINES];
   logic [31:0] m_data  [LINES];
   int          m_misses;

   function automatic logic [31:0] mem_word(input logic [31:0] waddr);
      if (backing.exists(waddr)) return backing[waddr];
      return waddr ^ 32'h5A5A_0F0F;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      m_misses = 0;
   endtask

   task automatic model_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int delay, output logic [31:0] exp_rdata, output int exp_stall);
      logic [31:0] waddr;
      int          idx;
      bit          hit;
      waddr = {addr[31:2], 2'b00};
      idx   = int'((addr >> 2) % LINES);
      hit   = m_valid[idx] && (m_waddr[idx] == waddr);
      exp_rdata = '0;
      if (we) begin
         backing[waddr] = wdata;
         if (hit) m_data[idx] = wdata;
         exp_stall = delay + 1;
      end else if (hit) begin
         exp_rdata = m_data[idx];
         exp_stall = 0;
      end else begin
         if (m_misses < 65535) m_misses++;
         m_valid[idx] = 1'b1;
         m_waddr[idx] = waddr;
         m_data[idx]  = mem_word(waddr);
         exp_rdata    = m_data[idx];
         exp_stall    = delay + 1;
      end
   endtask

   // Present one request, act as the backing memory (ack on the delay-th request cycle), and
   // return at the first stall-free cycle with the request still applied.
   task automatic run_op(input bit we, input bit re_too, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay,
                         output logic [31:0] rdata, output int nstall, output bit bus_ok);
      logic [31:0] waddr;
      int          nreq;
      waddr  = {addr[31:2], 2'b00};
      bus_ok = 1'b1;
      nstall = 0;
      nreq   = 0;
      @(negedge clk);
      cpu_addr  = addr;
      cpu_wdata = wdata;
      cpu_we    = we;
      cpu_re    = we ? re_too : 1'b1;
      mem_ack   = 1'b0;
      #1;
      while (stall && nstall < 200) begin
         nstall++;
         if (mem_req) begin
            nreq++;
            if (mem_we !== we || mem_addr !== waddr || (we && mem_wdata !== wdata)) bus_ok = 1'b0;
            if (nreq == delay) begin
               mem_ack = 1'b1;
               if (!we) mem_rdata = mem_word(waddr);
            end
         end else if (nstall > 1) begin
            bus_ok = 1'b0;
         end
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         #1;
      end
      if (mem_req || mem_we || mem_addr != 0 || mem_wdata != 0) bus_ok = 1'b0;
      rdata = cpu_rdata;
   endtask

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          delay;
      logic [31:0] exp_rdata;
      int          exp_stall;
      int          exp_miss;
   } vec_t;

   vec_t vecs[13];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, exp_rd;
      int          ns, exp_ns;
      bit          ok;

      vecs[0]  = '{1'b0, 32'h0000_0040, 32'h0,          3, 32'hDEAD_BEEF, 4, 1};
      vecs[1]  = '{1'b0, 32'h0000_0040, 32'h0,          1, 32'hDEAD_BEEF, 0, 1};
      vecs[2]  = '{1'b1, 32'h0000_0040, 32'h1234_5678,  2, 32'h0,         3, 1};
      vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0,          1, 32'h1234_5678, 0, 1};
      vecs[4]  = '{1'b1, 32'h0000_0080, 32'hCAFE_F00D,  2, 32'h0,         3, 1};
      vecs[5]  = '{1'b0, 32'h0000_0080, 32'h0,          1, 32'hCAFE_F00D, 2, 2};
      vecs[6]  = '{1'b0, 32'h0000_0040, 32'h0,          1, 32'h1234_5678, 2, 3};
      vecs[7]  = '{1'b0, 32'h0000_0440, 32'h0,          2, 32'h4404_4044, 3, 4};
      vecs[8]  = '{1'b0, 32'h0000_0040, 32'h0,          1, 32'h1234_5678, 2, 5};
      vecs[9]  = '{1'b0, 32'h0000_0043, 32'h0,          1, 32'h1234_5678, 0, 5};
      vecs[10] = '{1'b0, 32'h0000_007C, 32'h0,          4, 32'h7C7C_7C7C, 5, 6};
      vecs[11] = '{1'b1, 32'h0000_007E, 32'hA5A5_A5A5,  1, 32'h0,         2, 6};
      vecs[12] = '{1'b0, 32'h0000_007C, 32'h0,          1, 32'hA5A5_A5A5, 0, 6};

      backing[32'h40]  = 32'hDEAD_BEEF;
      backing[32'h440] = 32'h4404_4044;
      backing[32'h7C]  = 32'h7C7C_7C7C;

      rst = 1'b1; cpu_addr = '0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
      mem_rdata = '0; mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset stall",      32'(stall),      0);
      check("reset mem_req",    32'(mem_req),    0);
      check("reset mem_we",     32'(mem_we),     0);
      check("reset mem_addr",   mem_addr,        0);
      check("reset mem_wdata",  mem_wdata,       0);
      check("reset cpu_rdata",  cpu_rdata,       0);
      check("reset miss_count", 32'(miss_count), 0);
      model_reset();

      // Directed vector table.
      foreach (vecs[i]) begin
         model_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].delay, exp_rd, exp_ns);
         run_op(vecs[i].we, 1'b0, vecs[i].addr, vecs[i].wdata, vecs[i].delay, rd, ns, ok);
         check($sformatf("vec%0d stall_cycles", i), 32'(ns), 32'(vecs[i].exp_stall));
         check($sformatf("vec%0d bus", i), 32'(ok), 1);
         if (!vecs[i].we) check($sformatf("vec%0d cpu_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d miss_count", i), 32'(miss_count), 32'(vecs[i].exp_miss));
      end

      // A store held beyond its commit cycle is issued again.
      model_op(1'b1, 32'h44, 32'h0BAD_F00D, 1, exp_rd, exp_ns);
      run_op(1'b1, 1'b0, 32'h44, 32'h0BAD_F00D, 1, rd, ns, ok);
      check("held_we commit stall_cycles", 32'(ns), 32'(exp_ns));
      @(negedge clk); #1;
      check("held_we restarts write", 32'(stall), 1);
      @(negedge clk); #1;
      check("held_we second mem_req", 32'(mem_req), 1);
      check("held_we second mem_wdata", mem_wdata, 32'h0BAD_F00D);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0;
      #1;
      check("held_we back to idle", 32'(stall), 0);

      // Reset during FILL: request drops, late ack is ignored, line stays invalid.
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      model_reset();
      cpu_addr = 32'h40; cpu_re = 1'b1; cpu_we = 1'b0;
      #1;
      check("rstfill miss stall", 32'(stall), 1);
      @(negedge clk); #1;
      check("rstfill in FILL mem_req", 32'(mem_req), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; cpu_re = 1'b0;
      #1;
      check("rstfill mem_req after reset", 32'(mem_req), 0);
      check("rstfill miss_count after reset", 32'(miss_count), 0);
      mem_ack = 1'b1; mem_rdata = 32'hBADB_AD00;
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      check("rstfill late ack mem_req", 32'(mem_req), 0);
      check("rstfill late ack stall", 32'(stall), 0);
      model_op(1'b0, 32'h40, 32'h0, 1, exp_rd, exp_ns);
      run_op(1'b0, 1'b0, 32'h40, 32'h0, 1, rd, ns, ok);
      check("rstfill reload stall_cycles", 32'(ns), 32'(exp_ns));
      check("rstfill reload cpu_rdata", rd, exp_rd);
      check("rstfill reload miss_count", 32'(miss_count), 1);

      // Randomized traffic against the reference model.
      for (int k = 0; k < 400; k++) begin
         bit          we, re_too;
         logic [31:0] addr, wdata;
         int          delay;
         we     = ($urandom_range(0, 9) < 3);
         re_too = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 7) == 0) addr = $urandom;
         else addr = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         wdata = $urandom;
         delay = $urandom_range(1, 4);
         model_op(we, addr, wdata, delay, exp_rd, exp_ns);
         run_op(we, re_too, addr, wdata, delay, rd, ns, ok);
         check($sformatf("rnd%0d stall_cycles", k), 32'(ns), 32'(exp_ns));
         check($sformatf("rnd%0d bus", k), 32'(ok), 1);
         if (!we) check($sformatf("rnd%0d cpu_rdata", k), rd, exp_rd);
         check($sformatf("rnd%0d miss_count", k), 32'(miss_count), 32'(m_misses));
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            cpu_re = 1'b0; cpu_we = 1'b0;
            #1;
            check($sformatf("rnd%0d idle stall", k), 32'(stall), 0);
            check($sformatf("rnd%0d idle cpu_rdata", k), cpu_rdata, 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
